gcd_engine: RTL and testbench
=============================

# gcd_engine

Parametrised greatest-common-divisor engine with an integrated controller. It replaces the hand-wired datapath-plus-external-controller arrangement with one self-sequencing block. Operands are accepted over a valid/ready handshake, reduced by subtractive Euclid (one subtraction per cycle), and the result, iteration count and zero flag are returned over a second valid/ready handshake. It is used wherever a WIDTH-bit unsigned GCD is needed without per-design FSM glue.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- in_valid  input  1  operand pair present on data_a/data_b
- in_ready  output  1  engine can accept operands (high only in IDLE)
- data_a  input  WIDTH  operand A, unsigned
- data_b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result fields valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- data_d  output  WIDTH  gcd(A,B)
- iters  output  WIDTH  number of subtraction cycles used, saturating at 2^WIDTH−1
- zero  output  1  both operands were 0 (data_d = 0, undefined gcd)
- busy  output  1  state is CALC

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready at an edge: reg_a←data_a, reg_b←data_b, iters←0, go CALC. Without in_valid, stay in IDLE.
- CALC: one decision per cycle, in priority order:
  - reg_a==0 && reg_b==0 → data_d←0, zero←1, go DONE.
  - reg_a==0 or reg_b==0 → data_d←reg_a|reg_b, zero←0, go DONE.
  - reg_a==reg_b → data_d←reg_a, zero←0, go DONE.
  - reg_a>reg_b → reg_a←reg_a−reg_b, iters+1.
  - otherwise → reg_b←reg_b−reg_a, iters+1.
- DONE: out_valid=1. data_d, iters and zero stay stable until out_valid&out_ready at an edge, then go IDLE. Inputs are ignored in DONE and CALC.
- Arithmetic: subtraction is always larger minus smaller, so it never underflows. The comparator produces both the less-than and not-equal results. iters saturates and never wraps.
- reset asserted at any time, including mid-CALC or while out_valid is high: state goes to IDLE, reg_a/reg_b/data_d/iters go to 0, zero goes to 0. Any partial result is discarded and no out_valid pulse follows.
- Reset values: in_ready=1, out_valid=0, busy=0, data_d=0, iters=0, zero=0.

## Timing
- Accept edge T0. CALC runs during cycles T0..T0+k, where k is the number of subtractions. out_valid is high from edge T0+k+1.
- Latency from accept to out_valid is k+1 cycles. Minimum is 1 (equal or zero operands). Worst case is 2^WIDTH−1 (operands 2^WIDTH−1 and 1).
- in_ready, out_valid and busy are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Back-to-back: the result is consumed at edge Tn, in_ready goes high in the cycle after Tn, and the earliest next accept is edge Tn+1. Throughput is therefore at most one operation per k+3 cycles.
- out_ready held high before DONE has no effect. out_valid held with out_ready low holds indefinitely with all result outputs stable.

## Structure
- Shared package gcd_pkg holds:
  - the state encoding localparams (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default WIDTH.
- One sub-module, gcd_engine_dp: operand registers, two subtractors, input muxes, magnitude comparator (lt, neq, a_zero, b_zero), and the result register. It takes load/select strobes from the top-level FSM.
- The top level contains the FSM, the iters counter and the handshake logic.

## Test plan
- WIDTH=8. Apply (12,8) with out_ready=1 → data_d=4, iters=2, zero=0. out_valid rises 3 cycles after the accept edge and lasts one cycle.
- Apply (0,9), then (9,0), then (0,0) → data_d=9/9/0, iters=0, zero=0/0/1, latency 1 each.
- Apply (255,1) → data_d=1, iters=254, latency 255. Check in_ready stays low throughout and that in_valid pulses during CALC are ignored.
- Apply (36,24) with out_ready held low 5 cycles after out_valid → data_d=12, iters=2, all outputs stable while stalled. Issue the next pair on the accept edge immediately after release → correct second result.
- Assert reset mid-CALC of (200,3) → all outputs return to reset values asynchronously and no out_valid follows. A subsequent (21,14) returns 7.
- WIDTH=16: random pairs checked against a reference GCD, including the (65535,1) iters value of 65534.

Source files
------------

// File: rtl/gcd_pkg.sv
// rtl/gcd_pkg.sv - shared state encoding and default width for the GCD engine
// Purpose: common constants for gcd_engine and gcd_engine_dp.
// Contents: GCD_WIDTH (default operand width), IDLE/CALC/DONE encodings, state_t.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/gcd_engine_dp.sv
// rtl/gcd_engine_dp.sv - operand registers, subtractors, comparator and result register
// Purpose: datapath for subtractive Euclid, sequenced by strobes from gcd_engine.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   i_load            capture i_data_a/i_data_b into the operand registers
//   i_sub_a, i_sub_b  replace A with A-B, or B with B-A
//   i_cap             capture the result into the result register
//   i_data_a/b        operands
//   o_lt, o_neq       A<B, A!=B
//   o_a_zero/b_zero   operand register is zero
//   o_data_d          result register
module gcd_engine_dp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_sub_a,
  input  logic             i_sub_b,
  input  logic             i_cap,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  output logic             o_lt,
  output logic             o_neq,
  output logic             o_a_zero,
  output logic             o_b_zero,
  output logic [WIDTH-1:0] o_data_d
);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_d;

  logic [WIDTH-1:0] w_a_minus_b;
  logic [WIDTH-1:0] w_b_minus_a;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;

  // Only the larger-minus-smaller difference is ever written back.
  assign w_a_minus_b = r_a - r_b;
  assign w_b_minus_a = r_b - r_a;

  assign w_a_next = i_load ? i_data_a : w_a_minus_b;
  assign w_b_next = i_load ? i_data_b : w_b_minus_a;

  assign o_lt     = (r_a < r_b);
  assign o_neq    = (r_a != r_b);
  assign o_a_zero = (r_a == '0);
  assign o_b_zero = (r_b == '0);
  assign o_data_d = r_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a <= '0;
      r_b <= '0;
      r_d <= '0;
    end else begin
      if (i_load || i_sub_a) r_a <= w_a_next;
      if (i_load || i_sub_b) r_b <= w_b_next;
      // A|B covers all three terminations: both zero gives 0, one zero gives
      // the other operand, and equal operands give A.
      if (i_cap) r_d <= r_a | r_b;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// rtl/gcd_engine.sv - self-sequencing subtractive-Euclid GCD engine
// Purpose: accepts an operand pair over valid/ready, reduces it one subtraction
// per cycle, returns gcd, iteration count and zero flag over valid/ready.
// Ports:
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   in_valid, in_ready         operand handshake (in_ready high only in IDLE)
//   data_a, data_b             operands
//   out_valid, out_ready       result handshake (out_valid high only in DONE)
//   data_d, iters, zero        gcd, subtraction count (saturating), both-zero flag
//   busy                       engine is in CALC
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_d,
  output logic [WIDTH-1:0] iters,
  output logic             zero,
  output logic             busy
);

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_zero;
  logic [WIDTH-1:0] r_iters;

  logic w_lt;
  logic w_neq;
  logic w_a_zero;
  logic w_b_zero;
  logic w_calc;
  logic w_done;
  logic w_load;
  logic w_sub_a;
  logic w_sub_b;
  logic w_cap;

  assign w_calc  = (r_state == ST_CALC);
  assign w_done  = w_a_zero | w_b_zero | ~w_neq;
  assign w_load  = (r_state == ST_IDLE) & in_valid;
  assign w_sub_a = w_calc & ~w_done & ~w_lt;
  assign w_sub_b = w_calc & ~w_done & w_lt;
  assign w_cap   = w_calc & w_done;

  gcd_engine_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_load),
    .i_sub_a  (w_sub_a),
    .i_sub_b  (w_sub_b),
    .i_cap    (w_cap),
    .i_data_a (data_a),
    .i_data_b (data_b),
    .o_lt     (w_lt),
    .o_neq    (w_neq),
    .o_a_zero (w_a_zero),
    .o_b_zero (w_b_zero),
    .o_data_d (data_d)
  );

  // Handshake flags are registered alongside the state so they never depend
  // combinationally on in_valid or out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_zero      <= 1'b0;
      r_iters     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_state    <= ST_CALC;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_iters    <= '0;
          end
        end
        ST_CALC: begin
          if (w_done) begin
            r_state     <= ST_DONE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
            r_zero      <= w_a_zero & w_b_zero;
          end else if (r_iters != {WIDTH{1'b1}}) begin
            r_iters <= r_iters + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign zero      = r_zero;
  assign iters     = r_iters;

endmodule

// File: tb/tb_gcd_engine.sv
// tb/tb_gcd_engine.sv - directed and reference-model checks for gcd_engine
module tb_gcd_engine;

  localparam int LIMIT = 70000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        tb_in_valid = 1'b0;
  logic        tb_out_ready = 1'b1;
  logic [15:0] tb_a = '0;
  logic [15:0] tb_b = '0;
  logic        sel16 = 1'b0;

  logic       iv8, ir8, ov8, z8, b8;
  logic [7:0] d8, k8;
  logic        iv16, ir16, ov16, z16, b16;
  logic [15:0] d16, k16;

  logic        m_in_ready, m_out_valid, m_zero, m_busy;
  logic [15:0] m_data_d, m_iters;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign iv8  = tb_in_valid & ~sel16;
  assign iv16 = tb_in_valid & sel16;

  assign m_in_ready  = sel16 ? ir16 : ir8;
  assign m_out_valid = sel16 ? ov16 : ov8;
  assign m_zero      = sel16 ? z16  : z8;
  assign m_busy      = sel16 ? b16  : b8;
  assign m_data_d    = sel16 ? d16  : {8'd0, d8};
  assign m_iters     = sel16 ? k16  : {8'd0, k8};

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .data_a    (tb_a[7:0]),
    .data_b    (tb_b[7:0]),
    .out_valid (ov8),
    .out_ready (tb_out_ready),
    .data_d    (d8),
    .iters     (k8),
    .zero      (z8),
    .busy      (b8)
  );

  gcd_engine #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .reset     (rst_n),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .data_a    (tb_a),
    .data_b    (tb_b),
    .out_valid (ov16),
    .out_ready (tb_out_ready),
    .data_d    (d16),
    .iters     (k16),
    .zero      (z16),
    .busy      (b16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Modulo Euclid; the subtraction count is the sum of quotients minus one,
  // because the engine stops on equal operands rather than on a zero remainder.
  task automatic ref_gcd(input int a, input int b, output int g, output int k);
    int x, y, t;
    if (a == 0 || b == 0) begin
      g = a | b;
      k = 0;
    end else begin
      x = a;
      y = b;
      k = 0;
      while (y != 0) begin
        k += x / y;
        t = x % y;
        x = y;
        y = t;
      end
      g = x;
      k = k - 1;
    end
  endtask

  // Entered and left on a falling edge so consecutive calls issue back-to-back.
  task automatic run_op(input bit w16, input int a, input int b, input int exp_d,
                        input int exp_k, input int exp_z, input int exp_lat,
                        input int hold, input bit poke);
    int  lat;
    bit  bad_rdy, bad_busy, bad_hold;
    logic [15:0] sd, sk;
    logic        sz;
    sel16        = w16;
    tb_a         = a[15:0];
    tb_b         = b[15:0];
    tb_in_valid  = 1'b1;
    tb_out_ready = (hold == 0);
    check("in_ready_before_accept", m_in_ready, 1);
    lat = 0;
    bad_rdy = 0;
    bad_busy = 0;
    @(negedge clk);
    while (!m_out_valid && lat < LIMIT) begin
      if (m_in_ready) bad_rdy = 1;
      if (!m_busy) bad_busy = 1;
      tb_in_valid = poke ? lat[0] : 1'b0;
      tb_a = 16'($urandom);
      lat++;
      @(negedge clk);
    end
    tb_in_valid = 1'b0;
    check("done_in_budget", lat < LIMIT, 1);
    check("latency", lat, exp_lat);
    check("data_d", m_data_d, exp_d);
    check("iters", m_iters, exp_k);
    check("zero", m_zero, exp_z);
    check("in_ready_low_in_calc", bad_rdy, 0);
    check("busy_high_in_calc", bad_busy, 0);
    check("busy_low_in_done", m_busy, 0);
    if (hold > 0) begin
      sd = m_data_d;
      sk = m_iters;
      sz = m_zero;
      bad_hold = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!m_out_valid || m_data_d !== sd || m_iters !== sk || m_zero !== sz || m_in_ready)
          bad_hold = 1;
      end
      check("stall_stable", bad_hold, 0);
      tb_out_ready = 1'b1;
    end
    @(negedge clk);
    check("out_valid_one_cycle", m_out_valid, 0);
    check("in_ready_after_consume", m_in_ready, 1);
  endtask

  initial begin
    int g, k, a, b;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_in_ready", ir8, 1);
    check("rst_out_valid", ov8, 0);
    check("rst_busy", b8, 0);
    check("rst_data_d", d8, 0);
    check("rst_iters", k8, 0);
    check("rst_zero", z8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(0, 12, 8, 4, 2, 0, 3, 0, 0);
    run_op(0, 0, 9, 9, 0, 0, 1, 0, 0);
    run_op(0, 9, 0, 9, 0, 0, 1, 0, 0);
    run_op(0, 0, 0, 0, 0, 1, 1, 0, 0);
    run_op(0, 255, 1, 1, 254, 0, 255, 0, 1);
    run_op(0, 36, 24, 12, 2, 0, 3, 5, 0);
    run_op(0, 15, 10, 5, 2, 0, 3, 0, 0);

    // Reset in the middle of (200,3): previous result 5 must be cleared too.
    sel16 = 1'b0;
    tb_a = 16'd200;
    tb_b = 16'd3;
    tb_in_valid = 1'b1;
    @(negedge clk);
    tb_in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_reset_busy", b8, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", ir8, 1);
    check("arst_out_valid", ov8, 0);
    check("arst_busy", b8, 0);
    check("arst_data_d", d8, 0);
    check("arst_iters", k8, 0);
    check("arst_zero", z8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (300) begin
      @(negedge clk);
      if (ov8) seen = 1;
    end
    check("no_out_valid_after_reset", seen, 0);
    run_op(0, 21, 14, 7, 2, 0, 3, 0, 0);

    run_op(1, 65535, 1, 1, 65534, 0, 65535, 0, 0);
    for (int i = 0; i < 8; i++) begin
      a = int'($urandom_range(256, 65535));
      b = int'($urandom_range(256, 65535));
      ref_gcd(a, b, g, k);
      run_op(1, a, b, g, k, 0, k + 1, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
